instruction_fetch: RTL
======================

# instruction_fetch

Instruction fetch stage of the 32-bit processor. Holds the program counter and issues word reads to the `Ram` block over its `enable` / `read_write` / `address` / `data_out` interface. Captures each returned word into an output register and presents it to decode with a valid/ready handshake. Also accepts branch redirects from execute and counts delivered instructions.

## Interface

Parameters:
- `DATA_SIZE`, 32, instruction / memory word width.
- `ADDRESS_SIZE`, 16, PC and memory address width; memory is word-addressed.
- `RESET_PC`, 0, PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `mem_enable`  out  1  drives Ram `enable`.
- `mem_read_write`  out  1  drives Ram `read_write`; constant 1 (read). This block never writes; Ram `data_in` is tied off at top level.
- `mem_address`  out  ADDRESS_SIZE  drives Ram `address`.
- `mem_data`  in  DATA_SIZE  from Ram `data_out`; combinational read, valid in the same cycle as `mem_enable`/`mem_address`.
- `branch_taken`  in  1  redirect request from execute.
- `branch_target`  in  ADDRESS_SIZE  redirect PC; sampled only when `branch_taken`=1.
- `instr`  out  DATA_SIZE  fetched instruction word.
- `instr_pc`  out  ADDRESS_SIZE  address `instr` was fetched from.
- `instr_valid`  out  1  `instr` / `instr_pc` hold a live instruction.
- `instr_ready`  in  1  decode accepts; handshake completes on an edge with `instr_valid`=1 and `instr_ready`=1.
- `fetch_count`  out  32  number of completed handshakes since reset.

## Operation

- States: IDLE, REQUEST, HOLD.
- Reset (`reset_n`=0 at an edge): state IDLE, `pc`=RESET_PC, `instr`=0, `instr_pc`=0, `instr_valid`=0, `fetch_count`=0. Reset overrides every other input, including a branch in the same cycle.
- Combinational outputs:
  - `mem_enable` = (state==REQUEST).
  - `mem_address` = `pc` in all states.
  - `mem_read_write` = 1.
- IDLE:
  - Next state is always REQUEST.
  - If `branch_taken`=1, `pc` <= `branch_target`.
- REQUEST, no branch: `instr` <= `mem_data`, `instr_pc` <= `pc`, `instr_valid` <= 1, next state HOLD.
- REQUEST with `branch_taken`=1: the read data is discarded. `instr`, `instr_pc` and `instr_valid` are unchanged (`instr_valid` is 0 here). `pc` <= `branch_target`; state stays REQUEST.
- HOLD, no handshake, no branch: all registers hold. `instr` is stable for as long as `instr_ready`=0.
- HOLD with handshake, no branch: `instr_valid` <= 0, `pc` <= `pc`+1, `fetch_count` <= `fetch_count`+1, next state REQUEST.
- HOLD with `branch_taken`=1:
  - `instr_valid` <= 0, `pc` <= `branch_target`, next state REQUEST.
  - If the handshake completes in the same cycle, `fetch_count` increments: the instruction counts as delivered, and the target replaces `pc`+1.
- Arithmetic:
  - `pc`+1 is modulo 2^ADDRESS_SIZE, so 0xFFFF wraps to 0x0000 with no flag.
  - `fetch_count` is modulo 2^32.

## Timing

- First edge with `reset_n`=1: IDLE->REQUEST.
- Following cycle: `mem_enable`=1 with `mem_address`=RESET_PC.
- `instr_valid` rises at the edge closing the REQUEST cycle. This is 2 edges after reset release and 1 edge after entering REQUEST.
- Steady-state throughput is one instruction per 2 cycles (REQUEST + HOLD) when `instr_ready` is held high.
- Branch latency: `mem_address`=`branch_target` in the cycle after the edge sampling `branch_taken`. The target's instruction is valid one edge later.
- `instr_valid` never drops without a handshake, a branch, or a reset.
- `mem_enable` is never 1 in IDLE or HOLD.

## Test plan

- Reset and first fetch: preload Ram words 0..3 = 0xA0000000..0xA0000003, RESET_PC=0, `instr_ready`=1 -> `mem_enable` pulses at addresses 0,1,2,3 every 2 cycles. `instr` shows 0xA0000000..0xA0000003 with matching `instr_pc`; `fetch_count`=4 after the fourth handshake.
- Backpressure: `instr_ready`=0 for 5 cycles while `instr_valid`=1 -> `instr`, `instr_pc`, `pc` and `fetch_count` unchanged and `mem_enable`=0 throughout. Raising ready completes exactly one handshake.
- Branch in HOLD with simultaneous handshake: `branch_target`=0x0100 -> `fetch_count` +1. The next `mem_address` is 0x0100 (not `pc`+1), and the next `instr_pc`=0x0100.
- Branch in REQUEST: `branch_taken`=1 with target 0x0200 while reading 0x0005 -> the word at 0x0005 is never presented. The next REQUEST drives 0x0200, and `instr` = mem[0x0200].
- Wrap-around: branch to 0xFFFF, accept it -> the next fetch address is 0x0000 and `instr_pc`=0x0000.
- Reset mid-operation: assert `reset_n`=0 in HOLD with `instr_valid`=1 and `branch_taken`=1 -> at the next edge `instr_valid`=0, `fetch_count`=0, `pc`=RESET_PC, and the branch is ignored.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, reads words from Ram and hands them
// to decode over a valid/ready handshake, with branch redirect and a delivered count.
//
// state   | meaning
// IDLE    | out of reset, PC loaded, no read issued yet
// REQUEST | Ram read in flight at pc (mem_enable=1)
// HOLD    | instr valid, waiting for decode to accept
module instruction_fetch #(
  parameter int DATA_SIZE = 32,
  parameter int ADDRESS_SIZE = 16,
  parameter logic [ADDRESS_SIZE-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic                    mem_enable,
  output logic                    mem_read_write,
  output logic [ADDRESS_SIZE-1:0] mem_address,
  input  logic [DATA_SIZE-1:0]    mem_data,
  input  logic                    branch_taken,
  input  logic [ADDRESS_SIZE-1:0] branch_target,
  output logic [DATA_SIZE-1:0]    instr,
  output logic [ADDRESS_SIZE-1:0] instr_pc,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [31:0]             fetch_count
);

  typedef enum logic [1:0] {IDLE, REQUEST, HOLD} state_t;

  state_t                  state;
  logic [ADDRESS_SIZE-1:0] pc;
  logic                    handshake;

  assign handshake      = instr_valid & instr_ready;
  assign mem_enable     = (state == REQUEST);
  assign mem_address    = pc;
  assign mem_read_write = 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQUEST;
          if (branch_taken) pc <= branch_target;
        end
        REQUEST: begin
          // A redirect discards the word read this cycle and re-reads at the target.
          if (branch_taken) begin
            pc <= branch_target;
          end else begin
            instr       <= mem_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (handshake) fetch_count <= fetch_count + 32'd1;
          if (branch_taken) begin
            instr_valid <= 1'b0;
            pc          <= branch_target;
            state       <= REQUEST;
          end else if (handshake) begin
            instr_valid <= 1'b0;
            pc          <= pc + 1'b1;
            state       <= REQUEST;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
